// File: rtl/ins_stream_encoder_pkg.sv
// ins_stream_encoder_pkg
//   Shared constants for the ThreadKraken instruction encoder/decoder pair.
//   Contents:
//     OP_*    4-bit opcode classes (instruction bits [4:1])
//     BR_*    legal BRANCH funct codes
//     TRD_*   legal MULTI (thread control) funct codes
//     EXC_*   legal EXC funct codes
//     enc_state_e   encoder control state
//     enc_result_t  encode result: legality flag + 32-bit word
package ins_stream_encoder_pkg;

    localparam logic [3:0] OP_CAL    = 4'd0;
    localparam logic [3:0] OP_CALI   = 4'd1;
    localparam logic [3:0] OP_SHIFT  = 4'd2;
    localparam logic [3:0] OP_LOADI  = 4'd3;
    localparam logic [3:0] OP_MEMOP  = 4'd4;
    localparam logic [3:0] OP_BRANCH = 4'd5;
    localparam logic [3:0] OP_EXC    = 4'd6;
    localparam logic [3:0] OP_MULTI  = 4'd7;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b010;
    localparam logic [2:0] BR_BGE  = 3'b011;
    localparam logic [2:0] BR_JAL  = 3'b111;

    localparam logic [2:0] TRD_INIT  = 3'b111;
    localparam logic [2:0] TRD_SLEEP = 3'b101;
    localparam logic [2:0] TRD_WAKE  = 3'b010;
    localparam logic [2:0] TRD_KILL  = 3'b000;

    localparam logic [2:0] EXC_JMP = 3'b001;
    localparam logic [2:0] EXC_RET = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_e;

    typedef struct packed {
        logic        ok;
        logic [31:0] word;
    } enc_result_t;

endpackage

// File: rtl/ins_stream_encoder_fifo.sv
// ins_fifo
//   Small synchronous show-ahead FIFO holding encoded instruction words.
//   full/empty are registered, so a pop does not free a slot for a push
//   until the following cycle.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     push, din         write request / data (ignored when full)
//     pop               read request (ignored when empty)
//     dout              head word, forced to 0 while empty
//     full, empty       registered status
module ins_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;
    logic [PW:0]      count_next;
    logic             full_reg;
    logic             empty_reg;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push & ~full_reg;
    assign pop_ok  = pop & ~empty_reg;

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + (PW+1)'(1);
            2'b01:   count_next = count_reg - (PW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage has no reset: contents are only visible while non-empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_next;
            full_reg  <= (count_next == (PW+1)'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    assign dout  = empty_reg ? '0 : mem[rd_ptr_reg];
    assign full  = full_reg;
    assign empty = empty_reg;

endmodule

// File: rtl/ins_stream_encoder.sv
// ins_stream_encoder
//   Packs field-level instruction requests into 32-bit ThreadKraken words
//   and streams them into instruction memory at sequential addresses,
//   starting at base_addr. Requests the decoder would flag invalid are
//   dropped and reported with a one-cycle enc_err pulse.
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     start, base_addr            begin a program at base_addr (IDLE only)
//     req_valid/req_ready         request handshake
//     req_last                    final request of the program
//     req_op/funct/rd/ra/rb/imm   instruction fields
//     req_mem_rd                  MEMOP load (1) / store (0)
//     req_use_ra                  request uses ra (enables ra/imm overlap check)
//     imem_wr_valid/ready         imem write handshake
//     imem_wr_addr/data           imem write address / encoded word
//     busy                        not IDLE
//     done                        one-cycle pulse after the program finished
//     enc_err                     one-cycle pulse: request rejected
//     addr_ovf                    sticky address wrap flag, cleared by start
module ins_stream_encoder
    import ins_stream_encoder_pkg::*;
#(
    parameter int AW    = 10,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_last,
    input  logic [3:0]    req_op,
    input  logic [2:0]    req_funct,
    input  logic [4:0]    req_rd,
    input  logic [4:0]    req_ra,
    input  logic [4:0]    req_rb,
    input  logic [15:0]   req_imm,
    input  logic          req_mem_rd,
    input  logic          req_use_ra,
    output logic          imem_wr_valid,
    input  logic          imem_wr_ready,
    output logic [AW-1:0] imem_wr_addr,
    output logic [31:0]   imem_wr_data,
    output logic          busy,
    output logic          done,
    output logic          enc_err,
    output logic          addr_ovf
);

    // Field packing plus the legality rules the decoder enforces.
    function automatic enc_result_t encode(
        input logic [3:0]  op,
        input logic [2:0]  funct,
        input logic [4:0]  rd,
        input logic [4:0]  ra,
        input logic [4:0]  rb,
        input logic [15:0] imm,
        input logic        mem_rd,
        input logic        use_ra
    );
        enc_result_t res;
        res.ok        = 1'b1;
        res.word      = '0;
        res.word[4:1] = op;
        res.word[7:5] = funct;
        case (op)
            OP_CAL, OP_SHIFT: begin
                res.word[31:27] = rd;
                res.word[26:22] = ra;
                res.word[21:17] = rb;
            end
            OP_CALI, OP_LOADI, OP_MEMOP, OP_BRANCH: begin
                res.word[31:27] = rd;
                res.word[26]    = ra[4];
                res.word[25:10] = imm;
                if (op == OP_MEMOP) begin
                    res.word[8] = mem_rd;
                end
                // ra[3:0] is not stored separately: the decoder reads it
                // from imm[15:12], so the two must agree when ra is used.
                if (use_ra && (ra[3:0] != imm[15:12])) begin
                    res.ok = 1'b0;
                end
                if ((op == OP_BRANCH) &&
                    !(funct inside {BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_JAL})) begin
                    res.ok = 1'b0;
                end
            end
            OP_EXC: begin
                if (!(funct inside {EXC_JMP, EXC_RET})) begin
                    res.ok = 1'b0;
                end
            end
            OP_MULTI: begin
                res.word[31:27] = rd;
                res.word[26:22] = ra;
                if (!(funct inside {TRD_INIT, TRD_SLEEP, TRD_WAKE, TRD_KILL})) begin
                    res.ok = 1'b0;
                end
            end
            default: begin
                res.ok = 1'b0;
            end
        endcase
        return res;
    endfunction

    enc_state_e    state_reg;
    enc_state_e    state_next;
    logic [AW-1:0] addr_reg;
    logic          addr_ovf_reg;
    logic          enc_err_reg;
    enc_result_t   enc;
    logic          accept;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   fifo_dout;

    assign enc    = encode(req_op, req_funct, req_rd, req_ra, req_rb,
                           req_imm, req_mem_rd, req_use_ra);
    assign accept = req_valid & req_ready;
    assign push   = accept & enc.ok;
    assign pop    = imem_wr_valid & imem_wr_ready;

    ins_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (enc.word),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // DRAIN leaves once the queue has emptied; a program whose requests
    // were all rejected therefore finishes without any write.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_RUN;
            ST_RUN:   if (accept && req_last) state_next = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg     <= '0;
            addr_ovf_reg <= 1'b0;
            enc_err_reg  <= 1'b0;
        end else begin
            enc_err_reg <= accept & ~enc.ok;
            if ((state_reg == ST_IDLE) && start) begin
                addr_reg     <= base_addr;
                addr_ovf_reg <= 1'b0;
            end else if (pop) begin
                addr_reg <= addr_reg + AW'(1);
                if (&addr_reg) begin
                    addr_ovf_reg <= 1'b1;
                end
            end
        end
    end

    assign req_ready     = (state_reg == ST_RUN) & ~fifo_full;
    assign imem_wr_valid = ~fifo_empty;
    assign imem_wr_addr  = addr_reg;
    assign imem_wr_data  = fifo_dout;
    assign busy          = (state_reg != ST_IDLE);
    assign done          = (state_reg == ST_DONE);
    assign enc_err       = enc_err_reg;
    assign addr_ovf      = addr_ovf_reg;

endmodule
